// File: rtl/diff_window_stats.sv
// diff_window_stats: collects WINDOW signed 8-bit differences and reports
// sum, floor mean, min and max per window through a valid/ready handoff.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_ACC  | accepting samples (in_ready=1), building the current window
// ST_HOLD | result held for the sink (out_valid=1), input stalled
module diff_window_stats #(
  parameter int WINDOW = 16,
  parameter int ACC_W  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 diff_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           sum_out,
  output logic [7:0]                 mean_out,
  output logic [7:0]                 min_out,
  output logic [7:0]                 max_out,
  output logic [$clog2(WINDOW):0]    count_out
);

  localparam int SH = $clog2(WINDOW);
  localparam int CW = SH + 1;
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  state_t                   state;
  logic [CW-1:0]            count;
  logic signed [ACC_W-1:0]  acc;
  logic signed [7:0]        run_min;
  logic signed [7:0]        run_max;

  logic signed [7:0]        din;
  logic signed [ACC_W-1:0]  din_ext;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [7:0]        min_next;
  logic signed [7:0]        max_next;

  assign din       = diff_in;
  assign din_ext   = {{(ACC_W-8){diff_in[7]}}, diff_in};
  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_HOLD);
  assign count_out = count;

  // Running statistics including the sample currently offered; the first
  // sample of a window seeds min/max directly.
  always_comb begin
    acc_next = acc + din_ext;
    min_next = run_min;
    max_next = run_max;
    if (count == '0) begin
      min_next = din;
      max_next = din;
    end else begin
      if (din < run_min) min_next = din;
      if (din > run_max) max_next = din;
    end
  end

  // Window FSM: accumulate, latch the result on the last accept, hold until consumed.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state    <= ST_ACC;
      count    <= '0;
      acc      <= '0;
      run_min  <= '0;
      run_max  <= '0;
      sum_out  <= '0;
      mean_out <= '0;
      min_out  <= '0;
      max_out  <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_valid) begin
            acc     <= acc_next;
            count   <= count + CW'(1);
            run_min <= min_next;
            run_max <= max_next;
            if (count == LAST) begin
              // Mean is the arithmetic shift of the sum; the ACC_W rule
              // guarantees these 8 bits hold the full floor result.
              sum_out  <= acc_next;
              mean_out <= acc_next[SH+7:SH];
              min_out  <= min_next;
              max_out  <= max_next;
              state    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state <= ST_ACC;
            count <= '0;
            acc   <= '0;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_diff_window_stats.sv
// Directed bench for diff_window_stats: a WINDOW=4/ACC_W=10 instance (a) and
// a default WINDOW=16/ACC_W=12 instance (b) share clock and reset.
module tb_diff_window_stats;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       clear_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [7:0] diff_a, mean_a, min_a, max_a;
  logic [9:0] sum_a;
  logic [2:0] count_a;

  logic       clear_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [7:0] diff_b, mean_b, min_b, max_b;
  logic [11:0] sum_b;
  logic [4:0] count_b;

  int n_tests = 0;
  int n_fail  = 0;

  diff_window_stats #(.WINDOW(4), .ACC_W(10)) dut_a (
    .clk(clk), .rst(rst), .clear(clear_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .diff_in(diff_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .sum_out(sum_a), .mean_out(mean_a), .min_out(min_a), .max_out(max_a),
    .count_out(count_a)
  );

  diff_window_stats dut_b (
    .clk(clk), .rst(rst), .clear(clear_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .diff_in(diff_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .sum_out(sum_b), .mean_out(mean_b), .min_out(min_b), .max_out(max_b),
    .count_out(count_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_a(input logic [7:0] d);
    in_valid_a = 1'b1;
    diff_a     = d;
    tick();
    in_valid_a = 1'b0;
  endtask

  task automatic feed_b(input logic [7:0] d);
    in_valid_b = 1'b1;
    diff_b     = d;
    tick();
    in_valid_b = 1'b0;
  endtask

  logic [7:0] vec_a [4] = '{8'h05, 8'hFE, 8'h10, 8'h80};

  initial begin
    clear_a = 0; in_valid_a = 0; out_ready_a = 0; diff_a = 0;
    clear_b = 0; in_valid_b = 0; out_ready_b = 0; diff_b = 0;

    // reset with input activity present
    rst = 1; in_valid_a = 1; in_valid_b = 1; diff_a = 8'h33; diff_b = 8'h33;
    tick(); tick();
    check_eq("rst_out_valid", {31'd0, out_valid_a}, 0);
    check_eq("rst_count", {29'd0, count_a}, 0);
    check_eq("rst_sum", {22'd0, sum_a}, 0);
    check_eq("rst_sum_b", {20'd0, sum_b}, 0);
    rst = 0; in_valid_a = 0; in_valid_b = 0;
    check_eq("rst_in_ready", {31'd0, in_ready_a}, 1);
    tick();
    check_eq("idle_count", {29'd0, count_a}, 0);

    // mixed-sign window, back-to-back
    for (int i = 0; i < 4; i++) begin
      in_valid_a = 1; diff_a = vec_a[i];
      tick();
      if (i == 1) check_eq("mid_count", {29'd0, count_a}, 2);
      if (i == 2) check_eq("mid_no_valid", {31'd0, out_valid_a}, 0);
    end
    in_valid_a = 0;
    check_eq("w4_out_valid", {31'd0, out_valid_a}, 1);
    check_eq("w4_sum", {22'd0, sum_a}, 32'h393);
    check_eq("w4_mean", {24'd0, mean_a}, 32'hE4);
    check_eq("w4_min", {24'd0, min_a}, 32'h80);
    check_eq("w4_max", {24'd0, max_a}, 32'h10);
    check_eq("w4_count", {29'd0, count_a}, 4);

    // backpressure: held result ignores input
    for (int i = 0; i < 5; i++) begin
      in_valid_a = (i % 2 == 0); diff_a = 8'h11;
      tick();
      check_eq("bp_in_ready", {31'd0, in_ready_a}, 0);
      check_eq("bp_sum", {22'd0, sum_a}, 32'h393);
      check_eq("bp_count", {29'd0, count_a}, 4);
    end
    in_valid_a = 0; out_ready_a = 1;
    tick();
    out_ready_a = 0;
    check_eq("ho_in_ready", {31'd0, in_ready_a}, 1);
    check_eq("ho_out_valid", {31'd0, out_valid_a}, 0);
    check_eq("ho_count", {29'd0, count_a}, 0);
    check_eq("ho_sum_kept", {22'd0, sum_a}, 32'h393);

    // extremes on the default-size instance
    in_valid_b = 1; diff_b = 8'h80;
    for (int i = 0; i < 16; i++) tick();
    in_valid_b = 0;
    check_eq("neg_valid", {31'd0, out_valid_b}, 1);
    check_eq("neg_sum", {20'd0, sum_b}, 32'h800);
    check_eq("neg_mean", {24'd0, mean_b}, 32'h80);
    check_eq("neg_min", {24'd0, min_b}, 32'h80);
    check_eq("neg_count", {27'd0, count_b}, 16);
    out_ready_b = 1; tick(); out_ready_b = 0;
    in_valid_b = 1; diff_b = 8'h7F;
    for (int i = 0; i < 16; i++) tick();
    in_valid_b = 0;
    check_eq("pos_sum", {20'd0, sum_b}, 32'h7F0);
    check_eq("pos_mean", {24'd0, mean_b}, 32'h7F);
    check_eq("pos_min", {24'd0, min_b}, 32'h7F);
    check_eq("pos_max", {24'd0, max_b}, 32'h7F);

    // clear mid-window with a coincident sample
    feed_a(8'h01);
    feed_a(8'h02);
    clear_a = 1; in_valid_a = 1; diff_a = 8'h40;
    tick();
    clear_a = 0; in_valid_a = 0;
    check_eq("clr_count", {29'd0, count_a}, 0);
    check_eq("clr_sum", {22'd0, sum_a}, 0);
    feed_a(8'h01);
    feed_a(8'h01);
    feed_a(8'h01);
    check_eq("clr_not_done", {31'd0, out_valid_a}, 0);
    check_eq("clr_count3", {29'd0, count_a}, 3);
    feed_a(8'h04);
    check_eq("clr_done", {31'd0, out_valid_a}, 1);
    check_eq("clr_sum7", {22'd0, sum_a}, 7);
    check_eq("clr_mean", {24'd0, mean_a}, 1);
    check_eq("clr_min", {24'd0, min_a}, 1);
    check_eq("clr_max", {24'd0, max_a}, 4);

    // reset while holding a result
    rst = 1; tick(); rst = 0;
    check_eq("hrst_valid", {31'd0, out_valid_a}, 0);
    check_eq("hrst_sum", {22'd0, sum_a}, 0);
    check_eq("hrst_mean", {24'd0, mean_a}, 0);
    check_eq("hrst_min", {24'd0, min_a}, 0);
    check_eq("hrst_max", {24'd0, max_a}, 0);
    check_eq("hrst_count", {29'd0, count_a}, 0);
    check_eq("hrst_valid_b", {31'd0, out_valid_b}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
